// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: shift/rotate/load/clear per enabled edge,
// plus an auto-burst engine that repeats one shift/rotate COUNT times.
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_MSB,
  input  logic             SIN_LSB,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_LSB,
  output logic             SOUT_MSB,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_LOAD = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  op_t              op_sel;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] op_result;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             burst_mode;

  assign burst_mode = (MODE >= 3'd1) && (MODE <= 3'd4);

  // While bursting, the latched operation replaces the live MODE input.
  assign op_sel = (state_q == BURST) ? op_q : op_t'(MODE);

  always_comb begin
    op_result = q_q;
    case (op_sel)
      OP_SHR:  op_result = {SIN_MSB, q_q[WIDTH-1:1]};
      OP_SHL:  op_result = {q_q[WIDTH-2:0], SIN_LSB};
      OP_ROR:  op_result = {q_q[0], q_q[WIDTH-1:1]};
      OP_ROL:  op_result = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      OP_LOAD: op_result = D;
      OP_CLR:  op_result = '0;
      default: op_result = q_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (EN) begin
      case (state_q)
        IDLE: begin
          if (START && burst_mode) begin
            if (COUNT == '0) begin
              done_d = 1'b1;
            end else begin
              q_d   = op_result;
              op_d  = op_t'(MODE);
              cnt_d = COUNT - CNT_W'(1);
              if (COUNT == CNT_W'(1)) done_d = 1'b1;
              else                    state_d = BURST;
            end
          end else begin
            q_d = op_result;
          end
        end
        BURST: begin
          q_d   = op_result;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign Q        = q_q;
  assign SOUT_LSB = q_q[0];
  assign SOUT_MSB = q_q[WIDTH-1];
  assign BUSY     = (state_q == BURST);
  assign DONE     = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed scenarios plus random traffic
// checked against a remaining-operations reference model.
module tb_universal_shift_register;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          RST, EN, SIN_MSB, SIN_LSB, START;
  logic [2:0]    MODE;
  logic [W-1:0]  D;
  logic [CW-1:0] COUNT;
  logic [W-1:0]  Q;
  logic          SOUT_LSB, SOUT_MSB, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  // Reference model: expected register, operations still owed by a burst.
  logic [W-1:0] m_q;
  logic [2:0]   m_op;
  int           m_left;
  logic         m_done;

  universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .RST(RST), .EN(EN), .MODE(MODE), .D(D),
    .SIN_MSB(SIN_MSB), .SIN_LSB(SIN_LSB), .START(START), .COUNT(COUNT),
    .Q(Q), .SOUT_LSB(SOUT_LSB), .SOUT_MSB(SOUT_MSB), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] apply_op(input logic [2:0] op, input logic [W-1:0] v);
    logic [W-1:0] top, r;
    top = {1'b1, {(W-1){1'b0}}};
    case (op)
      3'd1:    r = (v >> 1) | (SIN_MSB ? top : '0);
      3'd2:    r = (v << 1) | W'(SIN_LSB);
      3'd3:    r = (v >> 1) | (v[0] ? top : '0);
      3'd4:    r = (v << 1) | (v >> (W - 1));
      3'd5:    r = D;
      3'd6:    r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    if (RST) begin
      m_q = '0; m_left = 0; m_done = 1'b0;
    end else if (!EN) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_q    = apply_op(m_op, m_q);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (START && MODE >= 3'd1 && MODE <= 3'd4) begin
        if (COUNT == 0) begin
          m_done = 1'b1;
        end else begin
          m_q    = apply_op(MODE, m_q);
          m_op   = MODE;
          m_left = int'(COUNT) - 1;
          m_done = (COUNT == 1);
        end
      end else begin
        m_q = apply_op(MODE, m_q);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".Q"}, 32'(Q), 32'(m_q));
    check({tag, ".BUSY"}, 32'(BUSY), 32'(m_left > 0));
    check({tag, ".DONE"}, 32'(DONE), 32'(m_done));
    check({tag, ".SOUT_LSB"}, 32'(SOUT_LSB), 32'(m_q[0]));
    check({tag, ".SOUT_MSB"}, 32'(SOUT_MSB), 32'(m_q[W-1]));
  endtask

  task automatic idle_inputs();
    RST = 1'b0; EN = 1'b1; MODE = 3'd0; D = '0; SIN_MSB = 1'b0;
    SIN_LSB = 1'b0; START = 1'b0; COUNT = '0;
  endtask

  task automatic load(input logic [W-1:0] v);
    MODE = 3'd5; D = v; tick("load"); MODE = 3'd0;
    check("load_value", 32'(Q), 32'(v));
  endtask

  initial begin
    m_q = '0; m_op = 3'd0; m_left = 0; m_done = 1'b0;
    idle_inputs();
    RST = 1'b1;
    @(negedge clk);
    tick("reset");
    check("reset_q", 32'(Q), 32'h0);
    RST = 1'b0;

    // 1: reset aborts a running burst without a DONE pulse
    load(8'h3C);
    MODE = 3'd4; START = 1'b1; COUNT = 4'd5; tick("t1_start");
    START = 1'b0; MODE = 3'd0;
    check("t1_busy", 32'(BUSY), 32'h1);
    RST = 1'b1; tick("t1_rst");
    check("t1_rst_q", 32'(Q), 32'h0);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) tick("t1_after");

    // 2: load then shift right/left
    load(8'hA5);
    MODE = 3'd1; SIN_MSB = 1'b1; tick("t2_shr");
    check("t2_shr_q", 32'(Q), 32'hD2);
    check("t2_sout_lsb", 32'(SOUT_LSB), 32'h0);
    MODE = 3'd2; SIN_LSB = 1'b1; tick("t2_shl");
    check("t2_shl_q", 32'(Q), 32'hA5);
    idle_inputs();

    // 3 and 6: rotate-left burst of 3, with ignored MODE/START/COUNT mid-burst
    load(8'h81);
    MODE = 3'd4; START = 1'b1; COUNT = 4'd3; tick("t3_e1");
    check("t3_q1", 32'(Q), 32'h03);
    START = 1'b0; MODE = 3'd6; tick("t3_e2");
    check("t3_q2", 32'(Q), 32'h06);
    check("t3_busy2", 32'(BUSY), 32'h1);
    START = 1'b1; COUNT = 4'd7; tick("t3_e3");
    check("t3_q3", 32'(Q), 32'h0C);
    check("t3_done", 32'(DONE), 32'h1);
    check("t3_busy3", 32'(BUSY), 32'h0);
    START = 1'b0; tick("t6_direct");
    check("t6_clear", 32'(Q), 32'h0);
    idle_inputs();

    // 4: EN stall of two cycles after the first operation
    load(8'h81);
    MODE = 3'd4; START = 1'b1; COUNT = 4'd3; tick("t4_e1");
    START = 1'b0; MODE = 3'd0; EN = 1'b0;
    tick("t4_s1"); tick("t4_s2");
    check("t4_hold", 32'(Q), 32'h03);
    check("t4_busy", 32'(BUSY), 32'h1);
    EN = 1'b1; tick("t4_e2");
    check("t4_nodone", 32'(DONE), 32'h0);
    tick("t4_e3");
    check("t4_q", 32'(Q), 32'h0C);
    check("t4_done", 32'(DONE), 32'h1);
    tick("t4_after");

    // 5: degenerate counts
    load(8'h5A);
    MODE = 3'd1; START = 1'b1; COUNT = 4'd0; tick("t5_c0");
    check("t5_c0_q", 32'(Q), 32'h5A);
    check("t5_c0_done", 32'(DONE), 32'h1);
    START = 1'b0; MODE = 3'd0; tick("t5_c0_after");
    load(8'h01);
    MODE = 3'd3; START = 1'b1; COUNT = 4'd1; tick("t5_c1");
    check("t5_c1_q", 32'(Q), 32'h80);
    check("t5_c1_done", 32'(DONE), 32'h1);
    idle_inputs();
    tick("t5_after");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      RST     = ($urandom_range(0, 99) < 2);
      EN      = ($urandom_range(0, 99) < 85);
      MODE    = 3'($urandom_range(0, 7));
      D       = W'($urandom);
      SIN_MSB = 1'($urandom);
      SIN_LSB = 1'($urandom);
      START   = ($urandom_range(0, 99) < 30);
      COUNT   = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 3));
      if (START && !(MODE >= 3'd1 && MODE <= 3'd4) && COUNT == 0) COUNT = CW'(1);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit register with synchronous active-high reset, clock enable, and eight operating modes: hold, shift right/left, rotate right/left, parallel load, clear, and hold. It adds an auto-burst engine that runs COUNT shift/rotate operations without further input and reports BUSY/DONE. It is used as the general serial/parallel conversion and bit-manipulation register for the lab designs.

Parameters:
WIDTH, 8, register width in bits; must be >= 2.
CNT_W, 4, width of burst COUNT and of the internal down-counter.

Ports:
clk  input  1  rising-edge clock; the only clock.
RST  input  1  synchronous active-high reset; overrides every other input.
EN  input  1  clock enable; when 0, Q, burst state and counter are all frozen.
MODE  input  3  operation select (see Behaviour).
D  input  WIDTH  parallel load data.
SIN_MSB  input  1  serial bit entering at the MSB on a right shift.
SIN_LSB  input  1  serial bit entering at the LSB on a left shift.
START  input  1  burst request; sampled only in IDLE with EN=1.
COUNT  input  CNT_W  number of burst operations; latched with START.
Q  output  WIDTH  register contents.
SOUT_LSB  output  1  combinational copy of Q[0].
SOUT_MSB  output  1  combinational copy of Q[WIDTH-1].
BUSY  output  1  high while a burst is in progress.
DONE  output  1  one-cycle pulse when a burst completes.

Behaviour:
- All state updates on posedge clk. RST=1 sets Q=0, BUSY=0, DONE=0, counter=0, state=IDLE at that edge, regardless of EN. Reset during a burst aborts it, with no DONE.
- MODE encoding (one operation per enabled edge):
  - 000 hold.
  - 001 shift right: Q<={SIN_MSB,Q[W-1:1]}.
  - 010 shift left: Q<={Q[W-2:0],SIN_LSB}.
  - 011 rotate right: Q<={Q[0],Q[W-1:1]}.
  - 100 rotate left: Q<={Q[W-2:0],Q[W-1]}.
  - 101 load: Q<=D.
  - 110 clear: Q<=0.
  - 111 hold (reserved).
- States: IDLE, BURST.
- IDLE, EN=1, START=0: apply MODE directly. Latency is 1 edge.
- IDLE, EN=1, START=1, MODE in 001..100, COUNT!=0:
  - At that edge, perform the first operation, latch MODE, load counter with COUNT-1.
  - If COUNT=1: DONE=1 at that edge, stay IDLE, BUSY stays 0.
  - Otherwise: BUSY=1, go to BURST.
- IDLE, START=1, COUNT=0: Q unchanged, DONE=1 for one cycle, BUSY stays 0.
- IDLE, START=1, MODE not in 001..100: START ignored; MODE applied directly.
- BURST, EN=1:
  - Perform the latched operation and decrement the counter.
  - At the edge where the counter goes 1->0, the final operation is visible in Q, BUSY drops to 0, DONE=1 for exactly one cycle, and the state returns to IDLE.
  - A burst of N operations occupies exactly N enabled edges.
- BURST: MODE, D, START and COUNT are ignored. A START held high through completion does not restart until the edge after DONE.
- EN=0 in any state: no change to Q, counter, state or BUSY. DONE is cleared on the next edge.
- DONE defaults to 0 on every edge except the completion edge.
- COUNT may exceed WIDTH. Shifts continue, filling with serial inputs; rotates wrap modulo WIDTH.
- SOUT_* are combinational from Q, with no added latency.

Test Plan:
1. Reset: RST=1 during a burst with BUSY=1 and Q=8'h3C -> next edge Q=00, BUSY=0, DONE=0, and no DONE pulse later.
2. Load then shift: MODE=101, D=8'hA5 -> Q=A5. Then MODE=001, SIN_MSB=1 -> Q=D2, SOUT_LSB=0. Then MODE=010, SIN_LSB=1 -> Q=A5.
3. Burst rotate: Q=8'h81, START=1, MODE=100, COUNT=3 -> Q sequence 03, 06, 0C over 3 edges. BUSY high on edges 1-2, low at edge 3. DONE=1 for one cycle with Q=0C.
4. EN stall: repeat scenario 3 with EN=0 for 2 cycles after the first operation -> Q holds 03, BUSY stays 1, DONE is delayed by exactly 2 cycles, final Q=0C.
5. Degenerate counts: START with COUNT=0 -> DONE pulse, Q unchanged, BUSY never 1. START with COUNT=1, MODE=011, Q=01 -> Q=80 with DONE at the same edge.
6. Ignored inputs: during the burst in scenario 3, toggle MODE to 110 and pulse START with COUNT=7 -> no effect. Final Q=0C, then IDLE resumes direct mode control.
